// File: rtl/reg_bank_sequencer_if.sv
// Control bundle between the instruction sequencer and the register bank / ALU / data memory.
// The master side is the sequencer; the slave side is the datapath it drives.
interface reg_bank_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [7:0]       instr;
   logic             ir_load;
   logic             pc_en;
   logic             read_reg1;
   logic             read_reg2;
   logic [1:0]       alu_op;
   logic [3:0]       mem_addr;
   logic             mem_read;
   logic             mem_write;
   logic             mem_to_reg;
   logic             reg_write;
   logic             busy;
   logic             halted;
   logic [CNT_W-1:0] retired_count;

   modport master (
      input  start, instr,
      output ir_load, pc_en, read_reg1, read_reg2, alu_op, mem_addr, mem_read,
             mem_write, mem_to_reg, reg_write, busy, halted, retired_count
   );

   modport slave (
      output start, instr,
      input  ir_load, pc_en, read_reg1, read_reg2, alu_op, mem_addr, mem_read,
             mem_write, mem_to_reg, reg_write, busy, halted, retired_count
   );
endinterface

// File: rtl/reg_bank_sequencer.sv
// Multi-cycle sequencer for a 2-entry register bank, ALU and data memory.
// Every control output is a register loaded from the next-state decode.
module reg_bank_sequencer #(
   parameter int MEM_WAIT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   reg_bank_sequencer_if.master bus
);
   // state    | meaning
   // S_IDLE   | waiting for start
   // S_FETCH  | ir_load / pc_en pulse
   // S_DECODE | latch selects and address, dispatch on opcode
   // S_EXEC   | ALU add
   // S_MEM    | data-memory access, MEM_WAIT cycles
   // S_WB     | register write-back pulse
   // S_HALT   | stopped until reset
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

   state_t           state, state_nxt;
   logic [2:0]       wait_cnt, wait_nxt;
   logic [1:0]       op_q, op_cur;
   logic             retire;
   logic             ir_load_d, reg_write_d, mem_read_d, mem_write_d, busy_d, halted_d;
   logic [1:0]       alu_op_d;

   logic             ir_load_q, pc_en_q, rr1_q, rr2_q, mem_read_q, mem_write_q;
   logic             mem_to_reg_q, reg_write_q, busy_q, halted_q;
   logic [1:0]       alu_op_q;
   logic [3:0]       addr_q;
   logic [CNT_W-1:0] cnt_q;

   // During DECODE the opcode comes straight from the IR; afterwards from the latched copy.
   assign op_cur = (state == S_DECODE) ? bus.instr[7:6] : op_q;

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      retire    = 1'b0;
      case (state)
         S_IDLE:   if (bus.start) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            unique case (op_cur)
               OP_ADD:           state_nxt = S_EXEC;
               OP_LOAD, OP_STORE: begin
                  state_nxt = S_MEM;
                  wait_nxt  = WAIT_INIT;
               end
               default:          state_nxt = S_HALT;
            endcase
         end
         S_EXEC:   state_nxt = S_WB;
         S_MEM: begin
            if (wait_cnt == 3'd0) begin
               if (op_cur == OP_STORE) begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end else begin
                  state_nxt = S_WB;
               end
            end else begin
               wait_nxt = wait_cnt - 3'd1;
            end
         end
         S_WB: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase

      ir_load_d   = (state_nxt == S_FETCH);
      alu_op_d    = (state_nxt == S_EXEC) ? 2'b01 : 2'b00;
      mem_read_d  = (state_nxt == S_MEM) && (op_cur == OP_LOAD);
      // Store strobe only on the terminal count of the wait timer.
      mem_write_d = (state_nxt == S_MEM) && (op_cur == OP_STORE) && (wait_nxt == 3'd0);
      reg_write_d = (state_nxt == S_WB);
      busy_d      = (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      halted_d    = (state_nxt == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         wait_cnt     <= 3'd0;
         op_q         <= 2'b00;
         rr1_q        <= 1'b0;
         rr2_q        <= 1'b0;
         addr_q       <= 4'd0;
         ir_load_q    <= 1'b0;
         pc_en_q      <= 1'b0;
         alu_op_q     <= 2'b00;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_nxt;
         ir_load_q   <= ir_load_d;
         pc_en_q     <= ir_load_d;
         alu_op_q    <= alu_op_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         reg_write_q <= reg_write_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
         if (state == S_DECODE) begin
            op_q   <= bus.instr[7:6];
            rr1_q  <= bus.instr[5];
            rr2_q  <= bus.instr[4];
            addr_q <= bus.instr[3:0];
         end
         if (state_nxt == S_WB) mem_to_reg_q <= (state == S_MEM);
         if (retire && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.ir_load       = ir_load_q;
   assign bus.pc_en         = pc_en_q;
   assign bus.read_reg1     = rr1_q;
   assign bus.read_reg2     = rr2_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_read      = mem_read_q;
   assign bus.mem_write     = mem_write_q;
   assign bus.mem_to_reg    = mem_to_reg_q;
   assign bus.reg_write     = reg_write_q;
   assign bus.busy          = busy_q;
   assign bus.halted        = halted_q;
   assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: random programs compared cycle by cycle against an
// instruction-level timeline model, plus reset, halt and mid-store reset cases.
module tb_reg_bank_sequencer;
   localparam int MW = 3;
   localparam int CW = 3;

   typedef logic [18:0] vec_t;

   logic clk = 1'b0;
   logic reset;

   reg_bank_sequencer_if #(.CNT_W(CW)) bus_if ();
   reg_bank_sequencer #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   vec_t       exp_q[$];
   logic [7:0] prog[$];
   int         k;
   int         n_checks = 0;
   int         n_fail   = 0;

   logic       m_rr1, m_rr2, m_m2r;
   logic [3:0] m_addr;
   int         m_cnt;

   function automatic vec_t observed();
      return {bus_if.ir_load, bus_if.pc_en, bus_if.read_reg1, bus_if.read_reg2,
              bus_if.alu_op, bus_if.mem_addr, bus_if.mem_read, bus_if.mem_write,
              bus_if.mem_to_reg, bus_if.reg_write, bus_if.busy, bus_if.halted,
              bus_if.retired_count};
   endfunction

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %05h expected %05h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_rr1 = 1'b0; m_rr2 = 1'b0; m_m2r = 1'b0; m_addr = 4'd0; m_cnt = 0;
      exp_q.delete();
   endtask

   task automatic push(input bit ir, input bit al, input bit mr, input bit mw,
                       input bit rw, input bit bz, input bit hl);
      exp_q.push_back({ir, ir, m_rr1, m_rr2, {1'b0, al}, m_addr, mr, mw, m_m2r,
                       rw, bz, hl, CW'(m_cnt)});
   endtask

   task automatic retire();
      if (m_cnt < (1 << CW) - 1) m_cnt++;
   endtask

   // Expected cycle-by-cycle outputs for one instruction, from its opcode timeline.
   task automatic model_instr(input logic [7:0] ins);
      push(1, 0, 0, 0, 0, 1, 0);
      push(0, 0, 0, 0, 0, 1, 0);
      m_rr1 = ins[5]; m_rr2 = ins[4]; m_addr = ins[3:0];
      case (ins[7:6])
         2'b00: begin
            push(0, 1, 0, 0, 0, 1, 0);
            m_m2r = 1'b0;
            push(0, 0, 0, 0, 1, 1, 0);
            retire();
         end
         2'b01: begin
            for (int i = 0; i < MW; i++) push(0, 0, 1, 0, 0, 1, 0);
            m_m2r = 1'b1;
            push(0, 0, 0, 0, 1, 1, 0);
            retire();
         end
         2'b10: begin
            for (int i = 0; i < MW; i++) push(0, 0, 0, (i == MW - 1), 0, 1, 0);
            retire();
         end
         default: push(0, 0, 0, 0, 0, 0, 1);
      endcase
   endtask

   task automatic drive(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: expected trace exhausted", tag);
            return;
         end
         check(tag, observed(), exp_q.pop_front());
         bus_if.start = 1'($urandom);
         if (bus_if.ir_load === 1'b1 && k < prog.size()) begin
            bus_if.instr = prog[k];
            k++;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus_if.start = 1'b1;
      bus_if.instr = 8'h00;
      repeat (2) begin
         @(negedge clk);
         check("reset", observed(), '0);
      end
      reset = 1'b0;
      bus_if.start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle", observed(), '0);
      end

      // Random program ending in HALT; long enough to saturate the 3-bit counter.
      model_reset();
      prog.delete();
      for (int i = 0; i < 12; i++)
         prog.push_back({2'($urandom_range(0, 2)), 6'($urandom)});
      prog.push_back({2'b11, 6'($urandom)});
      foreach (prog[i]) model_instr(prog[i]);
      repeat (6) push(0, 0, 0, 0, 0, 0, 1);
      k = 0;
      bus_if.start = 1'b1;
      drive("run", exp_q.size());

      reset = 1'b1;
      @(negedge clk);
      check("halt_reset", observed(), '0);
      reset = 1'b0;
      bus_if.start = 1'b0;
      @(negedge clk);
      check("post_halt_idle", observed(), '0);

      // ADD then a STORE interrupted by reset in its first MEM cycle.
      model_reset();
      prog.delete();
      prog.push_back({2'b00, 6'($urandom)});
      prog.push_back(8'b10_0_0_1010);
      foreach (prog[i]) model_instr(prog[i]);
      k = 0;
      bus_if.start = 1'b1;
      drive("store_pre_reset", 7);
      reset = 1'b1;
      @(negedge clk);
      check("mid_store_reset", observed(), '0);
      reset = 1'b0;
      bus_if.start = 1'b0;
      repeat (MW) begin
         @(negedge clk);
         check("after_mid_reset", observed(), '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_bank_sequencer.md
Name: reg_bank_sequencer

Overview:
- Multi-cycle control FSM that sequences the 2-entry, 8-bit register bank, the ALU and the data memory for one instruction at a time.
- Holds the register-bank select lines stable for each instruction and issues reg_write as a single-cycle pulse during write-back, so a write can never retrigger.
- Sits between the instruction register and the register bank / ALU / data-memory control inputs.

Parameters:
- MEM_WAIT, 1, data-memory access cycles (1..7) spent in MEM state
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin execution; sampled only in IDLE
- instr  input  8  instruction from the instruction register, valid while ir_load is high and held afterwards. Fields: [7:6] opcode (00 ADD, 01 LOAD, 10 STORE, 11 HALT), [5] rs, [4] rt, [3:0] mem address
- ir_load  output  1  latch next instruction into IR (FETCH)
- pc_en  output  1  increment PC (FETCH)
- read_reg1  output  1  register bank read select 1 (= rs)
- read_reg2  output  1  register bank read select 2 / write target (= rt)
- alu_op  output  2  00 pass, 01 add; 01 only in EXEC of ADD
- mem_addr  output  4  data-memory address (= instr[3:0])
- mem_read  output  1  data-memory read strobe
- mem_write  output  1  data-memory write strobe
- mem_to_reg  output  1  1 = write-back data from memory, 0 = from ALU
- reg_write  output  1  register bank write enable, one-cycle pulse
- busy  output  1  high in any state except IDLE and HALT
- halted  output  1  high in HALT
- retired_count  output  CNT_W  instructions completed

Behaviour:
- All outputs are registered. On reset, state = IDLE, every output = 0 and retired_count = 0. Reset wins over all other inputs, including mid-instruction; a pending reg_write or mem_write is dropped.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: if start = 1, go to FETCH. Otherwise stay.
- FETCH (1 cycle): ir_load = 1 and pc_en = 1. Go to DECODE.
- DECODE (1 cycle): latch read_reg1 = instr[5], read_reg2 = instr[4] and mem_addr = instr[3:0]; hold these until the next DECODE. Next state by opcode:
  - ADD: EXEC
  - LOAD or STORE: MEM
  - HALT: HALT
- EXEC (1 cycle): alu_op = 01. Go to WB with mem_to_reg = 0.
- MEM: stay MEM_WAIT cycles, tracked by an internal wait counter.
  - LOAD: mem_read = 1 for all MEM cycles, then go to WB with mem_to_reg = 1.
  - STORE: mem_write = 1 in the last MEM cycle only. Increment retired_count, then go to FETCH.
- WB (1 cycle): reg_write = 1, mem_to_reg held. Increment retired_count. Go to FETCH.
- HALT: halted = 1, busy = 0. Stay until reset; start is ignored.
- Latency per instruction with MEM_WAIT = 1:
  - ADD: 4 cycles
  - LOAD: 4 cycles
  - STORE: 3 cycles
  - HALT: 2 cycles to halted
  - In general, LOAD = 3 + MEM_WAIT and STORE = 2 + MEM_WAIT.
- reg_write and mem_write are never high together. reg_write is never high for two consecutive cycles.
- retired_count saturates at all-ones and does not wrap. HALT is not counted.
- start asserted outside IDLE has no effect.

Test Plan:
- reset = 1 for 2 cycles with start = 1 -> all outputs 0, state IDLE; after release with start = 0, busy stays 0.
- start pulse, instr = 8'b00_1_0_0000 (ADD rs=1, rt=0), MEM_WAIT = 1 -> ir_load cycle 1; read_reg1 = 1, read_reg2 = 0 from cycle 3; alu_op = 01 cycle 3; reg_write = 1 only in cycle 4; retired_count = 1.
- instr = 8'b01_0_1_0101 (LOAD rt=1, addr 5), MEM_WAIT = 3 -> mem_addr = 5; mem_read high 3 cycles; then a single reg_write pulse with mem_to_reg = 1 and read_reg2 = 1.
- instr = 8'b10_0_0_1010 (STORE rt=0, addr 10), MEM_WAIT = 2 -> mem_write high exactly 1 cycle (2nd MEM cycle); reg_write stays 0; next cycle ir_load = 1.
- ADD then HALT (8'b11_000000) -> halted = 1, busy = 0; retired_count = 1; further start pulses ignored; reset returns to IDLE with count 0.
- reset asserted during MEM of a STORE with MEM_WAIT = 3 -> mem_write never asserted; next cycle all outputs 0; retired_count = 0.
